// File: rtl/text_grid_buffer.sv
// Character ring buffer for a scrolling text console: a command port edits the buffer,
// and a 4-stage raster pipeline maps pixel coordinates to the character under them.
module text_grid_buffer #(
    parameter int COLS       = 32,
    parameter int ROWS_BUF   = 64,
    parameter int ROWS_VIS   = 16,
    parameter int CELL_W     = 40,
    parameter int CELL_H     = 45,
    parameter int CHAR_W     = 5,
    parameter int BLANK_CODE = 31,
    parameter int V_ACTIVE   = 720
) (
    input  logic                        clk_pixel,
    input  logic                        sys_rst_pixel,
    input  logic                        char_valid_in,
    input  logic [1:0]                  cmd_in,
    input  logic [CHAR_W-1:0]           char_in,
    output logic                        char_ready_out,
    input  logic [1:0]                  scroll_dir_in,
    input  logic [10:0]                 hcount_in,
    input  logic [9:0]                  vcount_in,
    input  logic                        hsync_in,
    input  logic                        vsync_in,
    input  logic                        active_draw_in,
    output logic [CHAR_W-1:0]           char_out,
    output logic [$clog2(CELL_W)-1:0]   glyph_x_out,
    output logic [$clog2(CELL_H)-1:0]   glyph_y_out,
    output logic                        cell_valid_out,
    output logic                        cursor_here_out,
    output logic                        hsync_out,
    output logic                        vsync_out,
    output logic                        active_draw_out,
    output logic [$clog2(COLS)-1:0]     cursor_col_out,
    output logic [$clog2(ROWS_BUF)-1:0] cursor_line_out
);

    localparam int COL_W  = $clog2(COLS);
    localparam int LINE_W = $clog2(ROWS_BUF);
    localparam int ROW_W  = $clog2(ROWS_VIS);
    localparam int DEPTH  = COLS * ROWS_BUF;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int GX_W   = $clog2(CELL_W);
    localparam int GY_W   = $clog2(CELL_H);
    localparam int LU_W   = LINE_W + 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] LAST_CLR  = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
    localparam logic [CHAR_W-1:0] BLANK     = CHAR_W'(BLANK_CODE);
    localparam logic [LU_W-1:0]   LU_FULL   = LU_W'(ROWS_BUF);
    localparam logic [LU_W-1:0]   LU_VIS    = LU_W'(ROWS_VIS);
    localparam logic [LINE_W-1:0] VIS_L     = LINE_W'(ROWS_VIS);
    localparam logic [10:0]       HCW       = 11'(CELL_W);
    localparam logic [9:0]        VCH       = 10'(CELL_H);
    localparam logic [10:0]       COLS_H    = 11'(COLS);
    localparam logic [9:0]        ROWS_V    = 10'(ROWS_VIS);
    localparam logic [9:0]        VA        = 10'(V_ACTIVE);

    localparam logic [1:0] CMD_CHAR = 2'd0;
    localparam logic [1:0] CMD_NL   = 2'd1;
    localparam logic [1:0] CMD_BS   = 2'd2;
    localparam logic [1:0] CMD_CLR  = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_CLR_LINE, ST_CLR_ALL} state_t;

    state_t              state_q;
    logic                ready_q;
    logic [ADDR_W-1:0]   clr_cnt_q;
    logic [COL_W-1:0]    cursor_col_q;
    logic [LINE_W-1:0]   cursor_line_q;
    logic [LU_W-1:0]     lines_used_q;
    logic [LU_W-1:0]     view_off_q;

    logic                accept;
    logic                do_newline;
    logic                do_clear;
    logic                frame_step;
    logic [LU_W-1:0]     max_off;
    logic [LINE_W-1:0]   top_line;
    logic [ADDR_W-1:0]   line_base;
    logic [LINE_W-1:0]   next_line;
    logic [LU_W-1:0]     lines_used_d;

    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [CHAR_W-1:0]   wr_data;

    assign char_ready_out  = ready_q;
    assign cursor_col_out  = cursor_col_q;
    assign cursor_line_out = cursor_line_q;

    // ------------------------------------------------------------------ command side
    assign accept     = char_valid_in && ready_q;
    assign do_clear   = accept && (cmd_in == CMD_CLR);
    assign do_newline = accept && ((cmd_in == CMD_NL) ||
                                   ((cmd_in == CMD_CHAR) && (cursor_col_q == LAST_COL)));
    assign frame_step = (hcount_in == 11'd0) && (vcount_in == VA);

    assign max_off      = (lines_used_q > LU_VIS) ? (lines_used_q - LU_VIS) : '0;
    assign top_line     = (lines_used_q <= LU_VIS) ? '0 :
                          (cursor_line_q + LINE_W'(1) - VIS_L - LINE_W'(view_off_q));
    assign line_base    = ADDR_W'(cursor_line_q) * COLS_A;
    assign next_line    = cursor_line_q + LINE_W'(1);
    assign lines_used_d = (lines_used_q == LU_FULL) ? lines_used_q : (lines_used_q + LU_W'(1));

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = clr_cnt_q;
        wr_data = BLANK;
        unique case (state_q)
            ST_CLR_ALL:  wr_en = 1'b1;
            ST_CLR_LINE: begin
                wr_en   = 1'b1;
                wr_addr = line_base + ADDR_W'(clr_cnt_q[COL_W-1:0]);
            end
            default: begin
                if (accept && (cmd_in == CMD_CHAR)) begin
                    wr_en   = 1'b1;
                    wr_addr = line_base + ADDR_W'(cursor_col_q);
                    wr_data = char_in;
                end else if (accept && (cmd_in == CMD_BS) && (cursor_col_q != '0)) begin
                    wr_en   = 1'b1;
                    wr_addr = line_base + ADDR_W'(cursor_col_q - COL_W'(1));
                end
            end
        endcase
    end

    always_ff @(posedge clk_pixel) begin
        if (sys_rst_pixel) begin
            state_q       <= ST_CLR_ALL;
            ready_q       <= 1'b0;
            clr_cnt_q     <= '0;
            cursor_col_q  <= '0;
            cursor_line_q <= '0;
            lines_used_q  <= LU_W'(1);
            view_off_q    <= '0;
        end else begin
            unique case (state_q)
                ST_CLR_ALL: begin
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_q   <= ST_IDLE;
                        ready_q   <= 1'b1;
                        clr_cnt_q <= '0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
                    end
                end
                ST_CLR_LINE: begin
                    if (clr_cnt_q == LAST_CLR) begin
                        state_q   <= ST_IDLE;
                        ready_q   <= 1'b1;
                        clr_cnt_q <= '0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
                    end
                end
                default: begin
                    if (do_clear) begin
                        state_q       <= ST_CLR_ALL;
                        ready_q       <= 1'b0;
                        clr_cnt_q     <= '0;
                        cursor_col_q  <= '0;
                        cursor_line_q <= '0;
                        lines_used_q  <= LU_W'(1);
                    end else if (do_newline) begin
                        state_q       <= ST_CLR_LINE;
                        ready_q       <= 1'b0;
                        clr_cnt_q     <= '0;
                        cursor_col_q  <= '0;
                        cursor_line_q <= next_line;
                        lines_used_q  <= lines_used_d;
                    end else if (accept && (cmd_in == CMD_CHAR)) begin
                        cursor_col_q <= cursor_col_q + COL_W'(1);
                    end else if (accept && (cmd_in == CMD_BS) && (cursor_col_q != '0)) begin
                        cursor_col_q <= cursor_col_q - COL_W'(1);
                    end
                end
            endcase

            // An edit that snaps the view back to the cursor outranks a pending scroll step.
            if (do_clear || do_newline) begin
                view_off_q <= '0;
            end else if (frame_step) begin
                if ((scroll_dir_in == 2'd1) && (view_off_q < max_off)) begin
                    view_off_q <= view_off_q + LU_W'(1);
                end else if ((scroll_dir_in == 2'd2) && (view_off_q != '0)) begin
                    view_off_q <= view_off_q - LU_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------ pixel pipeline
    logic [10:0]       col_full;
    logic [9:0]        row_full;
    logic              in_area;

    logic [COL_W-1:0]  s1_col_q;
    logic [ROW_W-1:0]  s1_row_q;
    logic [GX_W-1:0]   s1_gx_q;
    logic [GY_W-1:0]   s1_gy_q;
    logic              s1_valid_q;

    logic [LINE_W-1:0] s1_line;
    logic [ADDR_W-1:0] s2_addr_q;
    logic [GX_W-1:0]   s2_gx_q;
    logic [GY_W-1:0]   s2_gy_q;
    logic              s2_valid_q;
    logic              s2_cur_q;

    logic [CHAR_W-1:0] rd_q;
    logic [GX_W-1:0]   s3_gx_q;
    logic [GY_W-1:0]   s3_gy_q;
    logic              s3_valid_q;
    logic              s3_cur_q;

    logic [CHAR_W-1:0] mem [DEPTH];

    logic [2:0]        sync_in;
    logic [2:0]        sync_out;

    assign col_full = hcount_in / HCW;
    assign row_full = vcount_in / VCH;
    assign in_area  = (col_full < COLS_H) && (row_full < ROWS_V);
    assign s1_line  = top_line + LINE_W'(s1_row_q);

    always_ff @(posedge clk_pixel) begin
        if (sys_rst_pixel) begin
            s1_col_q   <= '0;
            s1_row_q   <= '0;
            s1_gx_q    <= '0;
            s1_gy_q    <= '0;
            s1_valid_q <= 1'b0;
            s2_addr_q  <= '0;
            s2_gx_q    <= '0;
            s2_gy_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_cur_q   <= 1'b0;
            s3_gx_q    <= '0;
            s3_gy_q    <= '0;
            s3_valid_q <= 1'b0;
            s3_cur_q   <= 1'b0;
            char_out        <= BLANK;
            glyph_x_out     <= '0;
            glyph_y_out     <= '0;
            cell_valid_out  <= 1'b0;
            cursor_here_out <= 1'b0;
        end else begin
            s1_col_q   <= COL_W'(col_full);
            s1_row_q   <= ROW_W'(row_full);
            s1_gx_q    <= GX_W'(hcount_in % HCW);
            s1_gy_q    <= GY_W'(vcount_in % VCH);
            s1_valid_q <= in_area;

            s2_addr_q  <= ADDR_W'(s1_line) * COLS_A + ADDR_W'(s1_col_q);
            s2_gx_q    <= s1_gx_q;
            s2_gy_q    <= s1_gy_q;
            s2_valid_q <= s1_valid_q;
            s2_cur_q   <= s1_valid_q && (view_off_q == '0) &&
                          (s1_line == cursor_line_q) && (s1_col_q == cursor_col_q);

            s3_gx_q    <= s2_gx_q;
            s3_gy_q    <= s2_gy_q;
            s3_valid_q <= s2_valid_q;
            s3_cur_q   <= s2_cur_q;

            char_out        <= s3_valid_q ? rd_q : BLANK;
            glyph_x_out     <= s3_gx_q;
            glyph_y_out     <= s3_gy_q;
            cell_valid_out  <= s3_valid_q;
            cursor_here_out <= s3_cur_q;
        end
    end

    // Write and read share one block so a same-address collision returns the old data.
    always_ff @(posedge clk_pixel) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_q <= mem[s2_addr_q];
    end

    assign sync_in = {active_draw_in, vsync_in, hsync_in};

    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        logic [3:0] pipe_q;
        always_ff @(posedge clk_pixel) begin
            if (sys_rst_pixel) begin
                pipe_q <= '0;
            end else begin
                pipe_q <= {pipe_q[2:0], sync_in[gi]};
            end
        end
        assign sync_out[gi] = pipe_q[3];
    end

    assign hsync_out       = sync_out[0];
    assign vsync_out       = sync_out[1];
    assign active_draw_out = sync_out[2];

endmodule

// File: tb/tb_text_grid_buffer.sv
// Directed bench for text_grid_buffer: command edits, scrolling, wrap and reset,
// observed through the pixel pipeline and the cursor outputs.
module tb_text_grid_buffer;

    localparam int COLS  = 32;
    localparam int CW    = 40;
    localparam int CH    = 45;
    localparam int BLANK = 31;
    localparam int LIMIT = 5000;

    logic        clk = 1'b0;
    logic        sys_rst_pixel;
    logic        char_valid_in;
    logic [1:0]  cmd_in;
    logic [4:0]  char_in;
    logic        char_ready_out;
    logic [1:0]  scroll_dir_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        hsync_in, vsync_in, active_draw_in;
    logic [4:0]  char_out;
    logic [5:0]  glyph_x_out;
    logic [5:0]  glyph_y_out;
    logic        cell_valid_out, cursor_here_out;
    logic        hsync_out, vsync_out, active_draw_out;
    logic [4:0]  cursor_col_out;
    logic [5:0]  cursor_line_out;

    text_grid_buffer dut (
        .clk_pixel       (clk),
        .sys_rst_pixel   (sys_rst_pixel),
        .char_valid_in   (char_valid_in),
        .cmd_in          (cmd_in),
        .char_in         (char_in),
        .char_ready_out  (char_ready_out),
        .scroll_dir_in   (scroll_dir_in),
        .hcount_in       (hcount_in),
        .vcount_in       (vcount_in),
        .hsync_in        (hsync_in),
        .vsync_in        (vsync_in),
        .active_draw_in  (active_draw_in),
        .char_out        (char_out),
        .glyph_x_out     (glyph_x_out),
        .glyph_y_out     (glyph_y_out),
        .cell_valid_out  (cell_valid_out),
        .cursor_here_out (cursor_here_out),
        .hsync_out       (hsync_out),
        .vsync_out       (vsync_out),
        .active_draw_out (active_draw_out),
        .cursor_col_out  (cursor_col_out),
        .cursor_line_out (cursor_line_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [4:0] r_char;
    logic [5:0] r_gx, r_gy;
    logic       r_valid, r_cur, r_hs, early_valid, early_hs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic raster_idle();
        hcount_in      = 11'd1500;
        vcount_in      = 10'd800;
        hsync_in       = 1'b0;
        vsync_in       = 1'b0;
        active_draw_in = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!char_ready_out && n < LIMIT) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= LIMIT) check("ready_timeout", n, 0);
    endtask

    task automatic send_cmd(input logic [1:0] c, input logic [4:0] ch);
        int n;
        char_valid_in = 1'b1;
        cmd_in        = c;
        char_in       = ch;
        wait_ready(n);
        @(posedge clk); #1;
        char_valid_in = 1'b0;
        $display("cmd %0d char %0d accepted after %0d wait cycles, cursor now %0d/%0d",
                 c, ch, n, cursor_line_out, cursor_col_out);
    endtask

    // One-cycle pixel probe; outputs are sampled after edge 3 (should still be idle) and edge 4.
    task automatic read_pixel(input int h, input int v);
        hcount_in      = 11'(h);
        vcount_in      = 10'(v);
        hsync_in       = 1'b1;
        vsync_in       = 1'b1;
        active_draw_in = 1'b1;
        @(posedge clk); #1;
        raster_idle();
        @(posedge clk); @(posedge clk); #1;
        early_valid = cell_valid_out;
        early_hs    = hsync_out;
        @(posedge clk); #1;
        r_char  = char_out;
        r_gx    = glyph_x_out;
        r_gy    = glyph_y_out;
        r_valid = cell_valid_out;
        r_cur   = cursor_here_out;
        r_hs    = hsync_out;
        $display("pixel (%0d,%0d): char %0d gx %0d gy %0d valid %0d cursor %0d",
                 h, v, r_char, r_gx, r_gy, r_valid, r_cur);
    endtask

    task automatic frame(input logic [1:0] dir);
        scroll_dir_in = dir;
        hcount_in     = 11'd0;
        vcount_in     = 10'd720;
        @(posedge clk); #1;
        raster_idle();
        scroll_dir_in = 2'd0;
        $display("frame step dir %0d", dir);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        sys_rst_pixel = 1'b1;
        char_valid_in = 1'b0;
        cmd_in        = 2'd0;
        char_in       = 5'd0;
        scroll_dir_in = 2'd0;
        raster_idle();
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_ready", char_ready_out, 0);
        check("rst_char", char_out, BLANK);
        check("rst_cell_valid", cell_valid_out, 0);
        check("rst_cursor_here", cursor_here_out, 0);
        check("rst_hsync_out", hsync_out, 0);
        check("rst_cursor_col", cursor_col_out, 0);
        check("rst_cursor_line", cursor_line_out, 0);

        sys_rst_pixel = 1'b0;
        wait_ready(n);
        check("reset_clear_cycles", n, 2048);

        // All visible cells blank, pipelined one pixel per cycle
        bad = 0;
        for (int i = 0; i < 515; i++) begin
            if (i < 512) begin
                hcount_in = 11'((i % COLS) * CW + 3);
                vcount_in = 10'((i / COLS) * CH + 2);
            end else begin
                raster_idle();
            end
            @(posedge clk); #1;
            if (i >= 3) begin
                if (char_out !== 5'(BLANK) || cell_valid_out !== 1'b1) bad++;
            end
        end
        raster_idle();
        check("blank_cells_bad", bad, 0);

        read_pixel(0, 0);
        check("home_cursor_here", r_cur, 1);
        read_pixel(1280, 0);
        check("outside_valid", r_valid, 0);
        check("outside_char", r_char, BLANK);

        // Fill line 0 with 1..32 (32 wraps to 0 in 5 bits); last char wraps to line 1
        for (int k = 1; k <= 32; k++) send_cmd(2'd0, 5'(k));
        wait_ready(n);
        check("line_clear_cycles", n, 32);
        check("wrap_cursor_line", cursor_line_out, 1);
        check("wrap_cursor_col", cursor_col_out, 0);
        read_pixel(1279, 0);
        check("last_col_char", r_char, 0);
        check("last_col_gx", r_gx, 39);
        check("last_col_gy", r_gy, 0);
        check("last_col_valid", r_valid, 1);
        check("latency3_valid", early_valid, 0);
        check("latency3_hsync", early_hs, 0);
        check("latency4_hsync", r_hs, 1);
        read_pixel(39, 44);
        check("first_cell_char", r_char, 1);
        check("first_cell_gy", r_gy, 44);
        check("first_cell_cursor", r_cur, 0);
        read_pixel(15 * CW, CH);
        check("new_line_blank", r_char, BLANK);
        read_pixel(0, CH);
        check("cursor_cell_here", r_cur, 1);

        // Backspace at column 0 does nothing
        send_cmd(2'd2, 5'd0);
        check("bs0_ready", char_ready_out, 1);
        check("bs0_col", cursor_col_out, 0);
        check("bs0_line", cursor_line_out, 1);
        read_pixel(1279, 0);
        check("bs0_no_backwrap", r_char, 0);

        // Backspace at column 5
        for (int k = 10; k <= 14; k++) send_cmd(2'd0, 5'(k));
        send_cmd(2'd2, 5'd0);
        check("bs5_col", cursor_col_out, 4);
        read_pixel(4 * CW, CH);
        check("bs5_blanked", r_char, BLANK);
        read_pixel(3 * CW, CH);
        check("bs5_kept", r_char, 13);

        // A command pulsed while busy must be ignored
        send_cmd(2'd1, 5'd0);
        char_valid_in = 1'b1;
        cmd_in        = 2'd0;
        char_in       = 5'd5;
        repeat (3) @(posedge clk);
        #1;
        char_valid_in = 1'b0;
        wait_ready(n);
        check("busy_ignored_col", cursor_col_out, 0);
        check("busy_ignored_line", cursor_line_out, 2);

        // Clear screen, then 20 marked lines
        send_cmd(2'd3, 5'd0);
        wait_ready(n);
        check("clear_cycles", n, 2048);
        check("clear_col", cursor_col_out, 0);
        check("clear_line", cursor_line_out, 0);
        for (int i = 0; i < 20; i++) begin
            send_cmd(2'd0, 5'(i + 1));
            send_cmd(2'd1, 5'd0);
        end
        wait_ready(n);
        check("nl20_line", cursor_line_out, 20);
        read_pixel(0, 0);
        check("view0_top", r_char, 6);
        read_pixel(0, 15 * CH);
        check("view0_cursor_here", r_cur, 1);

        for (int f = 0; f < 10; f++) frame(2'd1);
        read_pixel(0, 0);
        check("scroll_clamped_top", r_char, 1);
        read_pixel(0, 15 * CH);
        check("scrolled_cursor_here", r_cur, 0);
        check("scrolled_row15", r_char, 16);

        frame(2'd2);
        read_pixel(0, 0);
        check("scroll_fwd_top", r_char, 2);

        send_cmd(2'd1, 5'd0);
        wait_ready(n);
        read_pixel(0, 0);
        check("nl_resets_view", r_char, 7);

        frame(2'd1);
        read_pixel(0, 0);
        check("scroll_one_top", r_char, 6);

        // Newline and frame step on the same cycle: newline wins
        char_valid_in = 1'b1;
        cmd_in        = 2'd1;
        scroll_dir_in = 2'd1;
        hcount_in     = 11'd0;
        vcount_in     = 10'd720;
        @(posedge clk); #1;
        char_valid_in = 1'b0;
        scroll_dir_in = 2'd0;
        raster_idle();
        wait_ready(n);
        read_pixel(0, 0);
        check("nl_beats_scroll", r_char, 8);

        // Ring wrap: 70 newlines overwrite line 6
        send_cmd(2'd3, 5'd0);
        for (int i = 0; i < 6; i++) send_cmd(2'd1, 5'd0);
        send_cmd(2'd0, 5'd9);
        for (int i = 0; i < 64; i++) send_cmd(2'd1, 5'd0);
        wait_ready(n);
        check("ring_line", cursor_line_out, 6);
        check("ring_col", cursor_col_out, 0);
        check("ring_lines_used", dut.lines_used_q, 64);
        read_pixel(0, 15 * CH);
        check("ring_line6_blank", r_char, BLANK);
        check("ring_cursor_here", r_cur, 1);

        // Reset during a clear restarts the full clear
        send_cmd(2'd0, 5'd3);
        send_cmd(2'd3, 5'd0);
        repeat (100) @(posedge clk);
        #1;
        sys_rst_pixel = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midclr_rst_ready", char_ready_out, 0);
        sys_rst_pixel = 1'b0;
        wait_ready(n);
        check("midclr_restart_cycles", n, 2048);
        check("midclr_col", cursor_col_out, 0);
        check("midclr_line", cursor_line_out, 0);
        read_pixel(0, 6 * CH);
        check("midclr_line6_blank", r_char, BLANK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
